imem_arbiter: RTL and testbench

Controller that owns the byte-lane instruction memory (four 8-bit synchronous banks, 1-cycle registered read) and shares it between two requesters. The first is the processor fetch port (32-bit word reads). The second is the program loader (a byte stream written sequentially from a boot address). While a load is in progress, the arbiter holds the processor and drives per-lane byte writes. In run mode it forwards fetch addresses and returns assembled words. It sits between the core's fetch stage, the loader (UART/debug front end) and the four memory banks.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_load_ptr.sv | 37 +++
 rtl/imem_arbiter.sv | 102 ++++++++++
 tb/tb_imem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_pkg;

   localparam int unsigned LANE_W = 2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Byte-lane write enable for a lane index within a 32-bit word.
   function automatic logic [3:0] lane_onehot(input logic [LANE_W-1:0] lane);
      return 4'(4'b0001 << lane);
   endfunction

endpackage

// File: rtl/imem_load_ptr.sv
// Loader byte pointer with saturating byte count and sticky overflow flag.
module imem_load_ptr #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BOOT_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              accept,
   output logic [ADDR_W-1:0] ptr,
   output logic [ADDR_W:0]   count,
   output logic              err,
   output logic              full_c
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << ADDR_W;

   // Once every byte of memory has been written, further bytes are dropped.
   assign full_c = (count == FULL_CNT);

   always_ff @(posedge clk) begin
      if (reset || start) begin
         ptr   <= ADDR_W'(BOOT_ADDR);
         count <= '0;
         err   <= 1'b0;
      end else if (accept) begin
         ptr <= ptr + ADDR_W'(1);
         if (full_c) begin
            err <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the byte-lane instruction memory between the fetch port and the
// program loader; the loader owns the banks while a load is in progress.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BOOT_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_rvalid,
   output logic [31:0]       fetch_rdata,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_err,
   output logic [ADDR_W:0]   ld_count,
   output logic              cpu_hold,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              full;
   logic              start;
   logic              accept;
   logic              unused_addr;

   assign start       = (state == ST_RUN) && ld_start;
   assign accept      = (state == ST_LOAD) && ld_valid;
   assign fetch_rdata = mem_rdata;
   assign unused_addr = ^{fetch_addr[31:ADDR_W], fetch_addr[1:0]};

   imem_load_ptr #(
      .ADDR_W    (ADDR_W),
      .BOOT_ADDR (BOOT_ADDR)
   ) u_load_ptr (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .accept (accept),
      .ptr    (ptr),
      .count  (ld_count),
      .err    (ld_err),
      .full_c (full)
   );

   // Mode sequencing and fetch-return flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_RUN;
         fetch_rvalid <= 1'b0;
      end else begin
         fetch_rvalid <= fetch_req && fetch_ready;
         case (state)
            ST_RUN:   if (ld_start) state <= ST_LOAD;
            ST_LOAD:  if (accept && ld_last) state <= ST_DRAIN;
            ST_DRAIN: state <= ST_RUN;
            default:  state <= ST_RUN;
         endcase
      end
   end

   // Bank steering: fetch address in RUN, loader pointer in LOAD.
   always_comb begin
      fetch_ready = 1'b0;
      ld_ready    = 1'b0;
      cpu_hold    = 1'b0;
      mem_addr    = fetch_addr[ADDR_W-1:2];
      mem_we      = 4'b0000;
      mem_wdata   = ld_byte;
      case (state)
         ST_RUN: begin
            fetch_ready = fetch_req && !ld_start;
            cpu_hold    = ld_start;
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            cpu_hold = 1'b1;
            mem_addr = ptr[ADDR_W-1:2];
            if (ld_valid && !full) begin
               mem_we = lane_onehot(ptr[LANE_W-1:0]);
            end
         end
         ST_DRAIN: begin
            cpu_hold = 1'b1;
         end
         default: begin
            cpu_hold = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench: two arbiters (ADDR_W=10 and ADDR_W=4) with byte-lane memory models.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        init_mem;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        ld_start, ld_valid, ld_last;
   logic [7:0]  ld_byte;

   logic        rdy0, rv0, ldr0, err0, hold0;
   logic [31:0] rd0, mrd0;
   logic [10:0] cnt0;
   logic [7:0]  ma0, wd0;
   logic [3:0]  we0;

   logic        rdy1, rv1, ldr1, err1, hold1;
   logic [31:0] rd1, mrd1;
   logic [4:0]  cnt1;
   logic [1:0]  ma1;
   logic [7:0]  wd1;
   logic [3:0]  we1;

   logic [7:0] m0 [4][256];
   logic [7:0] m1 [4][4];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_W(10), .BOOT_ADDR(0)) u0 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(rdy0), .fetch_rvalid(rv0), .fetch_rdata(rd0),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
      .ld_ready(ldr0), .ld_err(err0), .ld_count(cnt0), .cpu_hold(hold0),
      .mem_addr(ma0), .mem_we(we0), .mem_wdata(wd0), .mem_rdata(mrd0));

   imem_arbiter #(.ADDR_W(4), .BOOT_ADDR(0)) u1 (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(rdy1), .fetch_rvalid(rv1), .fetch_rdata(rd1),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
      .ld_ready(ldr1), .ld_err(err1), .ld_count(cnt1), .cpu_hold(hold1),
      .mem_addr(ma1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(mrd1));

   // Four byte-wide banks per instance, registered read (old data on collision).
   always @(posedge clk) begin
      if (init_mem) begin
         for (int l = 0; l < 4; l++) begin
            for (int w = 0; w < 256; w++) m0[l][w] <= 8'(w * 4 + l) ^ 8'hC3;
            for (int w = 0; w < 4; w++)   m1[l][w] <= 8'h00;
         end
         m0[0][5] <= 8'hEF; m0[1][5] <= 8'hBE; m0[2][5] <= 8'hAD; m0[3][5] <= 8'hDE;
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (we0[l]) m0[l][ma0] <= wd0;
            if (we1[l]) m1[l][ma1] <= wd1;
         end
      end
      mrd0 <= {m0[3][ma0], m0[2][ma0], m0[1][ma0], m0[0][ma0]};
      mrd1 <= {m1[3][ma1], m1[2][ma1], m1[1][ma1], m1[0][ma1]};
   end

   typedef struct {
      logic        st, v;
      logic [7:0]  b;
      logic        last, freq;
      logic [31:0] fa;
      logic        e_rdy, e_hold, e_ldr;
      logic [3:0]  e_we;
      logic [7:0]  e_ma;
      logic [10:0] e_cnt;
      logic        e_rv, chk_rd;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Drive one cycle of inputs at the falling edge, settle, then return for sampling.
   task automatic cyc(input logic st, input logic v, input logic [7:0] b, input logic last,
                      input logic freq, input logic [31:0] fa);
      @(negedge clk);
      ld_start = st; ld_valid = v; ld_byte = b; ld_last = last;
      fetch_req = freq; fetch_addr = fa;
      #1;
   endtask

   initial begin
      // 8-byte load table: start, 8 bytes, drain, two fetches with returns
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 11'd0, 1'b0, 1'b0, 32'h0};
      for (int i = 0; i < 8; i++)
         tbl[1 + i] = '{1'b0, 1'b1, 8'(17 * (i + 1)), (i == 7), 1'b0, 32'h0,
                        1'b0, 1'b1, 1'b1, 4'(1 << (i % 4)), 8'(i / 4), 11'(i), 1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h4, 1'b0, 1'b1, 1'b0, 4'h0, 8'd1, 11'd8, 1'b0, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 4'h0, 8'd1, 11'd8, 1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 11'd8, 1'b1, 1'b1, 32'h88776655};
      tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 11'd8, 1'b0, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 11'd8, 1'b1, 1'b1, 32'h44332211};

      reset = 1'b1; init_mem = 1'b1;
      ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
      fetch_req = 1'b0; fetch_addr = 32'h14;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rvalid", 32'(rv0), 32'd0);
      chk("rst_ld_ready", 32'(ldr0), 32'd0);
      chk("rst_ld_err", 32'(err0), 32'd0);
      chk("rst_ld_count", 32'(cnt0), 32'd0);
      chk("rst_cpu_hold", 32'(hold0), 32'd0);
      chk("rst_mem_we", 32'(we0), 32'd0);
      chk("rst_mem_addr", 32'(ma0), 32'd5);
      chk("rst_u1_count", 32'(cnt1), 32'd0);
      reset = 1'b0; init_mem = 1'b0;

      // Plain fetch of preloaded word 5
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h14);
      chk("f5_ready", 32'(rdy0), 32'd1);
      chk("f5_hold", 32'(hold0), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("f5_rvalid", 32'(rv0), 32'd1);
      chk("f5_rdata", rd0, 32'hDEADBEEF);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("f5_rvalid_drop", 32'(rv0), 32'd0);

      // Reset after three loaded bytes
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("rl_start_hold", 32'(hold0), 32'd1);
      cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 32'h0);
      chk("rl_ld_ready", 32'(ldr0), 32'd1);
      chk("rl_we0", 32'(we0), 32'h1);
      cyc(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0, 32'h0);
      chk("rl_we2", 32'(we0), 32'h4);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("rl_count3", 32'(cnt0), 32'd3);
      reset = 1'b1;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("rl_post_ld_ready", 32'(ldr0), 32'd0);
      chk("rl_post_count", 32'(cnt0), 32'd0);
      chk("rl_post_hold", 32'(hold0), 32'd0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
      chk("rl_fetch_ready", 32'(rdy0), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("rl_fetch_rdata", rd0, 32'hC0CCBBAA);

      // Table-driven 8-byte load and readback
      for (int k = 0; k < 14; k++) begin
         cyc(tbl[k].st, tbl[k].v, tbl[k].b, tbl[k].last, tbl[k].freq, tbl[k].fa);
         chk($sformatf("v%0d.fetch_ready", k), 32'(rdy0), 32'(tbl[k].e_rdy));
         chk($sformatf("v%0d.cpu_hold", k), 32'(hold0), 32'(tbl[k].e_hold));
         chk($sformatf("v%0d.ld_ready", k), 32'(ldr0), 32'(tbl[k].e_ldr));
         chk($sformatf("v%0d.mem_we", k), 32'(we0), 32'(tbl[k].e_we));
         chk($sformatf("v%0d.mem_addr", k), 32'(ma0), 32'(tbl[k].e_ma));
         chk($sformatf("v%0d.ld_count", k), 32'(cnt0), 32'(tbl[k].e_cnt));
         chk($sformatf("v%0d.rvalid", k), 32'(rv0), 32'(tbl[k].e_rv));
         if (tbl[k].chk_rd) chk($sformatf("v%0d.rdata", k), rd0, tbl[k].e_rd);
         if (tbl[k].v) chk($sformatf("v%0d.wdata", k), 32'(wd0), 32'(tbl[k].b));
      end

      // ld_start and fetch_req together: loader wins
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4);
      chk("sim_fetch_ready", 32'(rdy0), 32'd0);
      chk("sim_hold", 32'(hold0), 32'd1);
      cyc(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 32'h0);
      chk("sim_load_state", 32'(ldr0), 32'd1);
      chk("sim_no_rvalid", 32'(rv0), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("sim_drain_hold", 32'(hold0), 32'd1);
      chk("sim_drain_ldr", 32'(ldr0), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("sim_run_hold", 32'(hold0), 32'd0);

      // Fetch accepted, then ld_start: the word still returns
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h4);
      chk("fs_ready", 32'(rdy0), 32'd1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("fs_rvalid", 32'(rv0), 32'd1);
      chk("fs_rdata", rd0, 32'h88776655);
      chk("fs_hold", 32'(hold0), 32'd1);
      cyc(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 32'h0);
      chk("fs_we", 32'(we0), 32'h1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

      // Overflow on the 16-byte instance
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 17; i++) begin
         cyc(1'b0, 1'b1, 8'(i + 1), (i == 16), 1'b0, 32'h0);
         chk($sformatf("ov%0d.mem_we", i), 32'(we1), (i < 16) ? 32'(1 << (i % 4)) : 32'd0);
         chk($sformatf("ov%0d.ld_count", i), 32'(cnt1), (i < 16) ? 32'(i) : 32'd16);
         if (i < 16) chk($sformatf("ov%0d.mem_addr", i), 32'(ma1), 32'((i / 4) % 4));
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("ov_err", 32'(err1), 32'd1);
      chk("ov_count", 32'(cnt1), 32'd16);
      chk("ov_drain_hold", 32'(hold1), 32'd1);
      chk("ov_u0_err", 32'(err0), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h8);
      chk("ov_fetch_ready", 32'(rdy1), 32'd1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("ov_rdata", rd1, 32'h0C0B0A09);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      chk("ov_err_held", 32'(err1), 32'd1);
      cyc(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 32'h0);
      chk("ov_err_clear", 32'(err1), 32'd0);
      chk("ov_count_clear", 32'(cnt1), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
